// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch path: word width, canonical NOP and the
// {instr, pc} pair carried from fetch to decode.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries with synchronous flush. Push is accepted
// when full only if a pop happens in the same cycle; popping empty is a no-op.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request credit, redirect drop accounting and prefetch FIFO.
// Optional FETCH_STAGE_PERF_EN adds saturating perf_fetched/perf_stall/perf_flush counters.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [XLEN-1:0]   imem_rsp_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [XLEN-1:0]   Instr,
   output logic [XLEN-1:0]   instr_pc,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc
`ifdef FETCH_STAGE_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall,
   output logic [31:0]       perf_flush
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0]  fetch_pc;
   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    drop_cnt;
   logic [CW-1:0]    fifo_count;
   logic             fifo_empty;
   logic             fifo_full;
   fetch_entry_t     fifo_head;
   fetch_entry_t     rsp_entry;
   logic [CW:0]      drop_sum;
   logic             req_fire;
   logic             rsp_take;
   logic             do_pop;

   logic [XLEN-1:0]  pcq_mem [DEPTH];
   logic [AW-1:0]    pcq_wr;
   logic [AW-1:0]    pcq_rd;

   // fifo_full is implied by the credit sum; kept as a cheap second guard
   assign imem_req_valid = !redirect && (drop_cnt == '0) && !fifo_full &&
                           (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_take       = imem_rsp_valid && !redirect && (drop_cnt == '0);
   assign do_pop         = instr_valid && instr_ready && !redirect;
   assign drop_sum       = {1'b0, drop_cnt} + {1'b0, outstanding};

   assign rsp_entry.instr = imem_rsp_data;
   assign rsp_entry.pc    = pcq_mem[pcq_rd];

   assign instr_valid = !fifo_empty;
   assign Instr       = instr_valid ? fifo_head.instr : '0;
   assign instr_pc    = instr_valid ? fifo_head.pc    : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         pcq_wr      <= '0;
         pcq_rd      <= '0;
      end else if (redirect) begin
         // stale in-flight words, including one arriving right now, are discarded
         fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
         outstanding <= '0;
         drop_cnt    <= (imem_rsp_valid && drop_sum != '0) ? CW'(drop_sum - 1'b1) : CW'(drop_sum);
         pcq_wr      <= '0;
         pcq_rd      <= '0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            pcq_wr   <= pcq_wr + AW'(1);
         end
         if (rsp_take) pcq_rd <= pcq_rd + AW'(1);
         if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !redirect && req_fire) pcq_mem[pcq_wr] <= fetch_pc;
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rsp_take),
      .push_data (rsp_entry),
      .pop       (do_pop),
      .flush     (redirect),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

`ifdef FETCH_STAGE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         if (do_pop && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
         if (instr_ready && !instr_valid && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
         if (redirect && perf_flush != '1) perf_flush <= perf_flush + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model (request epochs, in-order memory queue,
// instruction queue) checked every cycle, plus directed literal checks of key scenarios.
module tb_fetch_stage;
   import riscv_pkg::*;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] Instr;
   logic [31:0] instr_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef FETCH_STAGE_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
`endif

   fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .Instr          (Instr),
      .instr_pc       (instr_pc),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_STAGE_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall),
      .perf_flush     (perf_flush)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] addr;
      int          epoch;
   } mreq_t;

   mreq_t        mq[$];
   fetch_entry_t fq[$];
   mreq_t        cur;
   bit           cur_v;
   int           cyc, epoch, last_due, lat;
   logic [31:0]  req_pc;
   int           tests, fails;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_0013;
   endfunction

   // A request is stale when it was issued before the most recent redirect.
   function automatic bit pred_req_valid();
      int st, lv;
      st = 0;
      lv = 0;
      foreach (mq[i]) begin
         if (mq[i].epoch != epoch) st++;
         else lv++;
      end
      if (cur_v) begin
         if (cur.epoch != epoch) st++;
         else lv++;
      end
      return !redirect && st == 0 && (fq.size() + lv) < DEPTH;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         bit pv;
         pv = pred_req_valid();
         chk("req_valid", {31'd0, imem_req_valid}, {31'd0, pv});
         if (pv) chk("req_addr", imem_req_addr, req_pc);
         chk("instr_valid", {31'd0, instr_valid}, {31'd0, fq.size() > 0});
         if (fq.size() > 0) begin
            chk("instr_pc", instr_pc, fq[0].pc);
            chk("instr", Instr, fq[0].instr);
         end
      end
   end

   always @(posedge clk) begin
      bit in_rst, fire, popv;
      int due;
      in_rst = reset;
      if (in_rst) begin
         mq.delete();
         fq.delete();
         cur_v    = 0;
         req_pc   = RESET_PC;
         last_due = cyc;
      end else begin
         fire = pred_req_valid() && imem_req_ready;
         popv = fq.size() > 0 && instr_ready && !redirect;
         if (redirect) begin
            fq.delete();
            req_pc = {redirect_pc[31:2], 2'b00};
            epoch++;
         end else begin
            if (popv) void'(fq.pop_front());
            if (cur_v && cur.epoch == epoch)
               fq.push_back('{instr: mem_word(cur.addr), pc: cur.addr});
         end
         if (fire) begin
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            mq.push_back('{due: due, addr: req_pc, epoch: epoch});
            last_due = due;
            req_pc   = req_pc + 32'd4;
         end
         cur_v = 0;
      end
      cyc++;
      #1;
      if (!in_rst && mq.size() > 0 && mq[0].due <= cyc) begin
         cur            = mq.pop_front();
         cur_v          = 1;
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(cur.addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      redirect = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!instr_valid && n < limit) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!instr_valid) begin
         fails++;
         $display("FAIL wait_instr_valid actual=timeout required=valid within %0d", limit);
      end
   endtask

   initial begin
      int n;
      tests = 0; fails = 0; cyc = 0; epoch = 0; last_due = 0; cur_v = 0;
      req_pc = RESET_PC;
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; instr_ready = 1'b0; lat = 1;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;

      // Reset values, first request timing, and FIFO filling while decode stalls
      do_reset();
      @(negedge clk);
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", Instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h0);
      wait_valid(20, n);
      chk("first_valid_latency", n, 2);
      chk("first_valid_pc", instr_pc, 32'h0);
      repeat (8) @(negedge clk);
      chk("stall_head_pc", instr_pc, 32'h0);
      chk("stall_head_instr", Instr, mem_word(32'h0));
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
      @(posedge clk); #1 instr_ready = 1'b1;
      repeat (20) @(posedge clk);

      // Redirect to 0x103 with two words in flight
      #1 lat = 3;
      do_reset();
      repeat (2) @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 32'h0000_0103;
      @(negedge clk);
      chk("redir_req_blocked", {31'd0, imem_req_valid}, 32'd0);
      @(posedge clk); #1 redirect = 1'b0;
      n = 0;
      @(negedge clk);
      while (!imem_req_valid && n < 30) begin @(negedge clk); n++; end
      chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
      wait_valid(30, n);
      chk("redir_first_pc", instr_pc, 32'h0000_0100);
      repeat (10) @(posedge clk);

      // Redirect coinciding with the only outstanding response
      #1 lat = 2; imem_req_ready = 1'b0;
      do_reset();
      imem_req_ready = 1'b1;
      @(posedge clk); #1 imem_req_ready = 1'b0;
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h0000_0100;
      @(posedge clk); #1 redirect = 1'b0; imem_req_ready = 1'b1;
      @(negedge clk);
      wait_valid(30, n);
      chk("rsp_redir_pc", instr_pc, 32'h0000_0100);
      chk("rsp_redir_instr", Instr, mem_word(32'h0000_0100));
      repeat (10) @(posedge clk);

      // Back-to-back redirects, latency 4
      #1 lat = 4;
      do_reset();
      repeat (3) @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 32'h0000_0200;
      @(posedge clk); #1 redirect_pc = 32'h0000_0300;
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      wait_valid(40, n);
      chk("b2b_first_pc", instr_pc, 32'h0000_0300);
      repeat (10) @(posedge clk);

      // Randomized traffic with occasional redirects and one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         #1;
         if (i % 200 == 0) lat = (i % 400 == 0) ? 3 : int'($urandom_range(1, 4));
         imem_req_ready = ($urandom % 2) == 0;
         instr_ready    = ($urandom % 4) != 0;
         redirect       = ($urandom % 40) == 0;
         redirect_pc    = $urandom;
         if (i == 1500) begin
            do_reset();
         end else begin
            @(posedge clk);
         end
      end
      #1 redirect = 1'b0;
      repeat (5) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode/immediate-extend stage.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers returned words in a small prefetch FIFO.
- Presents {Instr, PC} to decode with a valid/ready handshake. On a branch/jump redirect it flushes the FIFO and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, prefetch FIFO entries and maximum in-flight requests; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response word valid; always accepted, in request order
- imem_rsp_data  in  32  returned instruction word
- instr_valid  out  1  Instr/PC valid to decode
- instr_ready  in  1  decode consumes the current instruction
- Instr  out  32  instruction word fed to decode and extend
- instr_pc  out  32  PC of Instr
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new fetch PC, typically PC + ImmExt; bits [1:0] forced to 0

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; imem_req_valid=0, instr_valid=0, Instr=0, instr_pc=0.
- Request fire: imem_req_valid && imem_req_ready. Response fire: imem_rsp_valid.
- Issue rule: imem_req_valid=1 iff !redirect && drop_cnt==0 && (fifo_count + outstanding) < DEPTH.
  - imem_req_addr = fetch_pc.
  - Requests are combinationally withdrawn only under redirect.
  - Each request fire advances fetch_pc by 4; wrap-around is mod 2^32.
- Outstanding counter: +1 on request fire, −1 on response fire that is not dropped; both in one cycle leaves it unchanged.
- Response handling:
  - drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Otherwise the word is pushed into the FIFO with its PC.
  - Per-entry PC comes from a parallel pc FIFO written at request fire.
- Write on empty: a pushed word becomes visible on instr_valid the next cycle. Minimum latency is request fire → response → instr_valid one cycle later. There is no combinational rsp→instr bypass.
- Output: instr_valid = FIFO non-empty; Instr and instr_pc = FIFO head. Pop when instr_valid && instr_ready. Simultaneous push and pop is legal at any count, including full.
- FIFO cannot overflow, because of the issue credit rule. Popping an empty FIFO is a no-op.
- Redirect cycle (highest priority):
  - FIFO flushed; instr_valid=0 next cycle.
  - No pop is counted.
  - fetch_pc ← {redirect_pc[31:2],2'b00}.
  - drop_cnt ← drop_cnt + outstanding − (rsp fire this cycle ? 1 : 0), floor 0. The current-cycle response is itself dropped.
  - outstanding ← 0.
  - No request fires, since imem_req_valid is forced 0.
- Redirect while drop_cnt>0: counts accumulate as above.
- Reset mid-operation: all state returns to reset values. Responses returning after reset are undefined; the memory is reset with the same signal.

Optional Feature:
- Macro: FETCH_STAGE_PERF_EN.
- When defined, adds three 32-bit output ports, all saturating, all cleared on reset:
  - perf_fetched: count of instruction pops.
  - perf_stall: cycles with instr_ready && !instr_valid.
  - perf_flush: count of redirects.
- When undefined: ports and counters absent; function otherwise identical.

Decomposition:
- Shared package riscv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, and a fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc}.
- One sub-module, fetch_fifo: parameterised DEPTH, holds fetch_entry_t, with push/pop/flush/count/empty/full.
- Top level holds PC, credit, drop and handshake logic.

Test Plan:
- Reset with RESET_PC=0, memory ready always with 1-cycle response latency → requests at 0x0,0x4,0x8…; first instr_valid 2 cycles after the first request fire, with instr_pc=0x0.
- Decode holds instr_ready=0 for 10 cycles → FIFO fills to DEPTH=2; imem_req_valid=0 while full+outstanding==2; Instr stays head word at instr_pc=0x0.
- imem_req_ready toggled randomly, 3-cycle response latency → instruction stream contiguous and in order; no duplicated or skipped PC.
- redirect=1, redirect_pc=0x103 with 2 responses in flight → next request at addr 0x100; the two stale words are never presented; first valid instr_pc=0x100.
- Redirect in the same cycle as a response fire with outstanding=1 → drop_cnt=0 afterwards; next response accepted as PC 0x100 word.
- Back-to-back redirects on 2 consecutive cycles with memory latency 4 → only the second target's words appear; outstanding returns to 0 when idle.
